// File: rtl/gate_op_arbiter_if.sv
// gate_op_arbiter_if
// Bundles the two requester channels, the response channel and the
// per-requester completion counters of gate_op_arbiter.
//   master : requester/consumer side, drives reqN_* and resp_ready
//   slave  : arbiter side, drives reqN_ready, resp_* and done_cntN
// Parameter CNT_W sets the width of done_cnt0/done_cnt1 and must match the
// arbiter instance it is connected to.
interface gate_op_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic             req0_a;
    logic             req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic             req1_a;
    logic             req1_b;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic             resp_data;
    logic             resp_err;
    logic [CNT_W-1:0] done_cnt0;
    logic [CNT_W-1:0] done_cnt1;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_err,
        input  done_cnt0, done_cnt1
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_err,
        output done_cnt0, done_cnt1
    );
endinterface

// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter
// Two-requester round-robin arbiter in front of a single shared 1-bit gate
// evaluator. One transaction is in flight at a time: IDLE accepts a request,
// EXEC evaluates the latched op, RESP holds the result until the consumer
// takes it. Each completed response bumps a saturating per-requester counter.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : gate_op_arbiter_if.slave (request channels, response channel,
//            done_cnt0/done_cnt1)
//
// Parameters
//   CNT_W  : width of each completion counter (saturates at all-ones)
//
// Build option
//   GATE_ARB_ILLEGAL_OP_EN : when defined, op 7 reports resp_err = 1;
//   otherwise resp_err is a constant 0. op 7 always yields resp_data = 0
//   and is counted as a completed transaction either way.
module gate_op_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    gate_op_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic             resp_data_q, resp_data_d;
`ifdef GATE_ARB_ILLEGAL_OP_EN
    logic             resp_err_q, resp_err_d;
`endif
    logic [CNT_W-1:0] done_cnt0_q, done_cnt0_d;
    logic [CNT_W-1:0] done_cnt1_q, done_cnt1_d;

    logic grant_id;
    logic ready0;
    logic ready1;
    logic accept;

    // Shared gate evaluator; op 7 (illegal) evaluates to 0.
    function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            3'd0:    r = ~a;
            3'd1:    r = a & b;
            3'd2:    r = ~(a & b);
            3'd3:    r = a | b;
            3'd4:    r = ~(a | b);
            3'd5:    r = a ^ b;
            3'd6:    r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Round-robin pick: on a tie the requester that was not served last wins,
    // otherwise whichever one is asking. last_q resets to 1 so requester 0
    // wins the first tie.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign ready0 = rst_n && (state_q == IDLE) && bus.req0_valid && !grant_id;
    assign ready1 = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant_id;
    assign accept = ready0 || ready1;

    // Next-state logic: latch the granted request, evaluate it once, then hold
    // the result until the consumer handshakes it.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_d       = last_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
`ifdef GATE_ARB_ILLEGAL_OP_EN
        resp_err_d   = resp_err_q;
`endif
        done_cnt0_d  = done_cnt0_q;
        done_cnt1_d  = done_cnt1_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = grant_id ? bus.req1_op : bus.req0_op;
                    a_d     = grant_id ? bus.req1_a  : bus.req0_a;
                    b_d     = grant_id ? bus.req1_b  : bus.req0_b;
                    id_d    = grant_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = gate_eval(op_q, a_q, b_q);
`ifdef GATE_ARB_ILLEGAL_OP_EN
                resp_err_d   = (op_q == 3'd7);
`endif
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    last_d       = resp_id_q;
                    state_d      = IDLE;
                    if (!resp_id_q && (done_cnt0_q != CNT_MAX)) begin
                        done_cnt0_d = done_cnt0_q + CNT_ONE;
                    end
                    if (resp_id_q && (done_cnt1_q != CNT_MAX)) begin
                        done_cnt1_d = done_cnt1_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= 3'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= 1'b0;
`ifdef GATE_ARB_ILLEGAL_OP_EN
            resp_err_q   <= 1'b0;
`endif
            done_cnt0_q  <= '0;
            done_cnt1_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
`ifdef GATE_ARB_ILLEGAL_OP_EN
            resp_err_q   <= resp_err_d;
`endif
            done_cnt0_q  <= done_cnt0_d;
            done_cnt1_q  <= done_cnt1_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
`ifdef GATE_ARB_ILLEGAL_OP_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif
    assign bus.done_cnt0  = done_cnt0_q;
    assign bus.done_cnt1  = done_cnt1_q;

endmodule
